ex_muldiv_unit: RTL

- Iterative multiply/divide unit in the EX stage of the MIPS pipeline, directly downstream of the ID/EX pipeline register.
- Consumes the decoded mult/div/move op and both register read operands from ID/EX, and owns the architectural HI/LO registers.
- Raises a stall back to the hazard/pipeline control while a result is not yet available.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_sign_fix.sv | 17 +
 rtl/ex_muldiv_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - md_op_e    : 3-bit operation code presented from ID/EX
//   - md_state_e : iteration FSM states
//   - MdXlen     : default operand / HI/LO width
//   - md_is_signed: true for the signed arithmetic ops (MULT, DIV)
package muldiv_pkg;

    localparam int unsigned MdXlen = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate.
// Used as abs() on the operands (neg_i = sign bit) and to apply the
// recorded result sign to product / quotient / remainder.
//   val_i : input value
//   neg_i : negate when 1
//   res_o : neg_i ? -val_i : val_i (wraps modulo 2**Width)
module muldiv_sign_fix #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] val_i,
    input  logic             neg_i,
    output logic [Width-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + Width'(1)) : val_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU: shift-add, DIV/DIVU: restoring division, one bit per cycle,
// followed by a sign-fix cycle that writes HI/LO (33 cycles accept->valid).
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU complete at the
// accept edge using a combinational 64-bit multiply.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   op_valid_i    : ID/EX holds a mult/div/move op
//   op_i          : md_op_e operation code
//   flush_i       : squash the op presented this cycle
//   rs_data_i     : rs operand
//   rt_data_i     : rt operand
//   stall_o       : hold IF/ID/EX (combinational)
//   busy_o        : iterative op in flight
//   done_o        : one-cycle pulse after HI/LO written by MULT/DIV
//   hi_o, lo_o    : HI/LO registers
//   mf_data_o     : MFHI/MFLO read data (combinational)
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = MdXlen,
    parameter int unsigned CNT_W = 5      // 2**CNT_W must equal XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid_i,
    input  logic [2:0]      op_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [XLEN-1:0] rt_data_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic [XLEN-1:0] mf_data_o
);

    localparam int unsigned DW = 2 * XLEN;

    md_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   opnd_q;    // multiplicand or divisor magnitude
    logic [DW-1:0]     part_q;    // mul: {acc, multiplier}; div: {remainder, quotient}
    logic              neg_lo_q;  // product / quotient sign
    logic              neg_hi_q;  // remainder sign
    logic              div0_q;
    logic              is_div_q;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              done_q;

    logic              accept;
    logic              sgn_op;
    logic [XLEN-1:0]   abs_rs, abs_rt;
    logic [XLEN:0]     mul_sum;
    logic [DW-1:0]     mul_next;
    logic [XLEN:0]     div_shl;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [DW-1:0]     div_next;
    logic [DW-1:0]     prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign busy_o    = (state_q != IDLE);
    assign stall_o   = op_valid_i & ~flush_i & busy_o;
    assign accept    = op_valid_i & ~flush_i & ~busy_o;
    assign done_o    = done_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign mf_data_o = (op_i == MD_MFLO) ? lo_q : hi_q;

    assign sgn_op = md_is_signed(op_i);

    muldiv_sign_fix #(.Width(XLEN)) u_abs_rs (
        .val_i (rs_data_i),
        .neg_i (sgn_op & rs_data_i[XLEN-1]),
        .res_o (abs_rs)
    );

    muldiv_sign_fix #(.Width(XLEN)) u_abs_rt (
        .val_i (rt_data_i),
        .neg_i (sgn_op & rt_data_i[XLEN-1]),
        .res_o (abs_rt)
    );

    // Shift-add step: conditionally add multiplicand to the upper half,
    // then shift the whole {carry, acc, multiplier} right by one.
    assign mul_sum  = {1'b0, part_q[DW-1:XLEN]} + (part_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, part_q[XLEN-1:1]};

    // Restoring step: shift next dividend bit into the remainder, subtract
    // the divisor if it fits. The difference always fits XLEN bits when taken.
    assign div_shl  = part_q[DW-1:XLEN-1];
    assign div_ge   = (div_shl >= {1'b0, opnd_q});
    assign div_sub  = div_shl[XLEN-1:0] - opnd_q;
    assign div_next = div_ge ? {div_sub, part_q[XLEN-2:0], 1'b1}
                             : {div_shl[XLEN-1:0], part_q[XLEN-2:0], 1'b0};

    muldiv_sign_fix #(.Width(DW)) u_fix_prod (
        .val_i (part_q),
        .neg_i (neg_lo_q),
        .res_o (prod_fix)
    );

    muldiv_sign_fix #(.Width(XLEN)) u_fix_quo (
        .val_i (part_q[XLEN-1:0]),
        .neg_i (neg_lo_q),
        .res_o (quo_fix)
    );

    muldiv_sign_fix #(.Width(XLEN)) u_fix_rem (
        .val_i (part_q[DW-1:XLEN]),
        .neg_i (neg_hi_q),
        .res_o (rem_fix)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [DW-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{XLEN{sgn_op & rs_data_i[XLEN-1]}}, rs_data_i};
    assign fast_b    = {{XLEN{sgn_op & rt_data_i[XLEN-1]}}, rt_data_i};
    assign fast_prod = fast_a * fast_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            part_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (op_i)
                            MD_MULT, MD_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                                {hi_q, lo_q} <= fast_prod;
                                done_q       <= 1'b1;
`else
                                opnd_q   <= abs_rt;
                                part_q   <= {{XLEN{1'b0}}, abs_rs};
                                neg_lo_q <= sgn_op & (rs_data_i[XLEN-1] ^ rt_data_i[XLEN-1]);
                                neg_hi_q <= 1'b0;
                                div0_q   <= 1'b0;
                                is_div_q <= 1'b0;
                                cnt_q    <= '0;
                                state_q  <= MUL;
`endif
                            end
                            MD_DIV, MD_DIVU: begin
                                opnd_q   <= abs_rt;
                                part_q   <= {{XLEN{1'b0}}, abs_rs};
                                neg_lo_q <= sgn_op & (rs_data_i[XLEN-1] ^ rt_data_i[XLEN-1]);
                                neg_hi_q <= sgn_op & rs_data_i[XLEN-1];
                                div0_q   <= (rt_data_i == '0);
                                is_div_q <= 1'b1;
                                cnt_q    <= '0;
                                state_q  <= DIV;
                            end
                            MD_MTHI: hi_q <= rs_data_i;
                            MD_MTLO: lo_q <= rs_data_i;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    part_q <= mul_next;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= FIX;
                    end
                end
                DIV: begin
                    part_q <= div_next;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        // With a zero divisor the remainder path already
                        // reproduces rs; only the quotient is forced.
                        lo_q <= div0_q ? '1 : quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
